sound_player: RTL and testbench

Audio back end for the frogger design. Consumes the one-cycle `playsound` strobe and 2-bit `soundselector` code produced by the game-state block. Plays the selected effect as a short sequence of square-wave notes on a single speaker pin. Reports `busy` while playing and pulses `done` at the end.

---
 rtl/sound_pkg.sv | 34 +++
 rtl/sound_player_tone_gen.sv | 34 +++
 rtl/sound_player.sv | 107 ++++++++++
 tb/tb_sound_player.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared sound definitions: effect codes, note record and the effect table.
// Half-periods are in 25 MHz clock cycles; durations are in ms ticks.
package sound_pkg;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_e;

  // Duration is 9 bits so the 300 ms crash tail fits; 0 marks end of effect.
  typedef struct packed {
    logic [16:0] half_period;
    logic [8:0]  duration;
  } note_t;

  localparam logic [16:0] NOTE_REST = 17'd0;
  localparam logic [16:0] NOTE_C3   = 17'd95558;
  localparam logic [16:0] NOTE_G3   = 17'd63776;
  localparam logic [16:0] NOTE_C5   = 17'd23889;
  localparam logic [16:0] NOTE_E5   = 17'd18961;
  localparam logic [16:0] NOTE_G5   = 17'd15944;
  localparam logic [16:0] NOTE_C6   = 17'd11945;

  // Indexed by {effect, slot}.
  localparam note_t EFFECT_TABLE [16] = '{
    '{NOTE_C6,   9'd50},  '{NOTE_REST, 9'd0},   '{NOTE_REST, 9'd0},   '{NOTE_REST, 9'd0},
    '{NOTE_C5,   9'd100}, '{NOTE_E5,   9'd100}, '{NOTE_G5,   9'd100}, '{NOTE_REST, 9'd0},
    '{NOTE_G3,   9'd150}, '{NOTE_REST, 9'd50},  '{NOTE_C3,   9'd300}, '{NOTE_REST, 9'd0},
    '{NOTE_C5,   9'd120}, '{NOTE_E5,   9'd120}, '{NOTE_G5,   9'd120}, '{NOTE_C6,   9'd120}
  };

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator: toggles every half_period cycles while enabled.
// A latched half-period of 0 is a rest and never toggles.
module tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [16:0] half_period,
  output logic        tone
);

  logic [16:0] hp_q;
  logic [16:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_q <= '0;
      cnt  <= '0;
      tone <= 1'b0;
    end else if (load) begin
      hp_q <= half_period;
      cnt  <= half_period;
      tone <= 1'b0;
    end else if (en && hp_q != '0) begin
      if (cnt == 17'd1) begin
        cnt  <= hp_q;
        tone <= ~tone;
      end else begin
        cnt <= cnt - 17'd1;
      end
    end
  end

endmodule

// File: rtl/sound_player.sv
// Effect sequencer: walks the note slots of the selected effect, timing each
// note in ms ticks and driving the speaker from the tone generator.
module sound_player
  import sound_pkg::*;
#(
  parameter int TICK_DIV   = 25000,
  parameter int TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_index
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

  state_e        state;
  sound_e        sel;
  logic [1:0]    idx;
  logic [PW-1:0] presc;
  logic [8:0]    dur;
  note_t         note;
  logic [16:0]   hp_shift;
  logic [16:0]   hp_eff;
  logic          tone;

  assign note     = EFFECT_TABLE[{sel, idx}];
  assign hp_shift = note.half_period >> TONE_SHIFT;

  // A real note shifted down to 0 must still sound, so clamp it to 1.
  always_comb begin
    hp_eff = hp_shift;
    if (note.half_period != '0 && hp_shift == '0) hp_eff = 17'd1;
  end

  tone_gen u_tone (
    .clk         (clk),
    .reset       (reset),
    .load        (state == LOAD),
    .en          (state == PLAY),
    .half_period (hp_eff),
    .tone        (tone)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= UI_PRESS;
      idx   <= 2'd0;
      presc <= '0;
      dur   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // A new request wins over everything, including natural completion.
      if (playsound) begin
        state <= LOAD;
        sel   <= sound_e'(soundselector);
        idx   <= 2'd0;
      end else begin
        case (state)
          LOAD: begin
            if (note.duration == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              dur   <= note.duration;
              presc <= '0;
              state <= PLAY;
            end
          end
          PLAY: begin
            if (presc == PRESC_MAX) begin
              presc <= '0;
              dur   <= dur - 9'd1;
              if (dur == 9'd1) begin
                if (idx == 2'd3) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end else begin
                  idx   <= idx + 2'd1;
                  state <= LOAD;
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy       = (state != IDLE);
  assign note_index = idx;
  assign speaker    = tone & ~mute & (state == PLAY);

endmodule

// File: tb/tb_sound_player.sv
// Self-checking bench for sound_player: every cycle of each effect is compared
// against a timeline model built from the effect table.
module tb_sound_player;

  localparam int TICK  = 25;
  localparam int SHIFT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       playsound = 1'b0;
  logic [1:0] soundselector = 2'd0;
  logic       mute = 1'b0;
  logic       speaker, busy, done;
  logic [1:0] note_index;

  int errs = 0;
  int checks = 0;

  int hp_tab [4][4] = '{
    '{11945, 0, 0, 0},
    '{23889, 18961, 15944, 0},
    '{63776, 0, 95558, 0},
    '{23889, 18961, 15944, 11945}
  };
  int du_tab [4][4] = '{
    '{50, 0, 0, 0},
    '{100, 100, 100, 0},
    '{150, 50, 300, 0},
    '{120, 120, 120, 120}
  };

  sound_player #(.TICK_DIV(TICK), .TONE_SHIFT(SHIFT)) dut (
    .clk           (clk),
    .reset         (reset),
    .playsound     (playsound),
    .soundselector (soundselector),
    .mute          (mute),
    .speaker       (speaker),
    .busy          (busy),
    .done          (done),
    .note_index    (note_index)
  );

  always #5 clk = ~clk;

  // Timeline of an effect, k = samples since the strobe edge (k=1 is the first LOAD).
  function automatic void model(input int sel, input int k, input bit m,
                                output bit b, output bit s, output int ix, output bit d);
    int pos, du, h;
    pos = k - 1;
    b = 0; s = 0; ix = 0; d = 0;
    for (int i = 0; i < 4; i++) begin
      du = du_tab[sel][i];
      ix = i;
      if (pos == 0) begin b = 1; return; end
      if (du == 0) begin d = (pos == 1); return; end
      pos -= 1;
      if (pos < du * TICK) begin
        b = 1;
        if (hp_tab[sel][i] != 0) begin
          h = hp_tab[sel][i] >> SHIFT;
          if (h == 0) h = 1;
          s = ((pos / h) % 2 == 1) && !m;
        end
        return;
      end
      pos -= du * TICK;
    end
    ix = 3;
    d = (pos == 0);
  endfunction

  // Strobe an effect and compare every cycle until it has been idle 3 cycles or max_k.
  task automatic run_effect(input string name, input int sel, input int max_k,
                            input int mlo, input int mhi);
    bit eb, es, ed;
    int ei, idle_cnt;
    idle_cnt = 0;
    playsound = 1'b1;
    soundselector = 2'(sel);
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      playsound = 1'b0;
      mute = (k >= mlo && k < mhi);
      #1;
      model(sel, k, mute, eb, es, ei, ed);
      checks += 4;
      if (busy !== eb) begin errs++; $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, eb); end
      if (speaker !== es) begin errs++; $display("FAIL %s speaker k=%0d got %b want %b", name, k, speaker, es); end
      if (done !== ed) begin errs++; $display("FAIL %s done k=%0d got %b want %b", name, k, done, ed); end
      if (note_index !== 2'(ei)) begin errs++; $display("FAIL %s note_index k=%0d got %0d want %0d", name, k, note_index, ei); end
      if (!eb && k > 1) idle_cnt++;
      if (idle_cnt == 3) break;
    end
    mute = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    playsound = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if ({speaker, busy, done, note_index} !== 5'b0) begin
        errs++;
        $display("FAIL reset_idle cycle=%0d got spk=%b busy=%b done=%b idx=%0d want all 0",
                 c, speaker, busy, done, note_index);
      end
    end
  endtask

  task automatic test_ui_press();
    run_effect("ui_press", 0, 20000, 0, 0);
  endtask

  task automatic test_crash();
    run_effect("crash", 2, 20000, 0, 0);
  endtask

  task automatic test_celebration();
    run_effect("celebration", 3, 20000, 0, 0);
  endtask

  // NEXTLEVEL cut short by CRASH, with a random mute window during the crash.
  task automatic test_preempt();
    int cut, mlo;
    cut = 400 + $urandom_range(0, 200);
    mlo = 100 + $urandom_range(0, 3000);
    run_effect("preempt_nextlevel", 1, cut, 0, 0);
    run_effect("preempt_crash", 2, 20000, mlo, mlo + 2000 + $urandom_range(0, 2000));
  endtask

  task automatic test_async_reset();
    // k=50 lands on a high half of the C6 tone, so the drop is observable.
    run_effect("async_pre", 0, 50, 0, 0);
    #1 reset = 1'b1;
    #1;
    checks += 3;
    if (speaker !== 1'b0) begin errs++; $display("FAIL async_reset speaker got %b want 0", speaker); end
    if (busy !== 1'b0) begin errs++; $display("FAIL async_reset busy got %b want 0", busy); end
    if (note_index !== 2'd0) begin errs++; $display("FAIL async_reset note_index got %0d want 0", note_index); end
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    run_effect("after_reset", 1, 20000, 0, 0);
  endtask

  // Chain of random strobes preempting each other, last one runs to the end.
  task automatic test_random();
    int mlo;
    for (int r = 0; r < 3; r++) begin
      mlo = $urandom_range(0, 300);
      run_effect("random_cut", $urandom_range(0, 3), $urandom_range(50, 600),
                 mlo, mlo + $urandom_range(0, 300));
    end
    mlo = $urandom_range(0, 2000);
    run_effect("random_full", $urandom_range(0, 3), 20000, mlo, mlo + $urandom_range(0, 1500));
  endtask

  initial begin
    test_reset();
    test_ui_press();
    test_crash();
    test_celebration();
    test_preempt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
